// File: rtl/spi_xfer_sequencer_if.sv
// Command and spi_master-facing signal bundle for spi_xfer_sequencer.
// The master modport is the requester/SPI-engine side; the slave modport is the sequencer.
interface spi_xfer_sequencer_if #(
  parameter int MAX_BYTES = 4
);
  logic                     req;
  logic [2:0]               len;
  logic [8*MAX_BYTES-1:0]   tx_word;
  logic                     mlb_in;
  logic [1:0]               cdiv_in;
  logic                     ack;
  logic                     busy;
  logic                     xfer_done;
  logic                     err;
  logic [8*MAX_BYTES-1:0]   rx_word;
  logic                     frame;
  logic                     m_start;
  logic [7:0]               m_tdat;
  logic                     m_mlb;
  logic [1:0]               m_cdiv;
  logic                     m_done;
  logic [7:0]               m_rdata;

  modport master (
    output req, len, tx_word, mlb_in, cdiv_in, m_done, m_rdata,
    input  ack, busy, xfer_done, err, rx_word, frame, m_start, m_tdat, m_mlb, m_cdiv
  );

  modport slave (
    input  req, len, tx_word, mlb_in, cdiv_in, m_done, m_rdata,
    output ack, busy, xfer_done, err, rx_word, frame, m_start, m_tdat, m_mlb, m_cdiv
  );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Splits one packed multi-byte request into per-byte spi_master transfers,
// collecting received bytes into rx_word and flagging reject/timeout via err.
module spi_xfer_sequencer #(
  parameter int MAX_BYTES  = 4,
  parameter int START_LEN  = 2,
  parameter int GAP_CYCLES = 3,
  parameter int TIMEOUT    = 1023
) (
  input logic                 clk,
  input logic                 rst,
  spi_xfer_sequencer_if.slave bus
);
  localparam int W  = 8 * MAX_BYTES;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_GAP, S_FINISH} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  tx_q, tx_d;
  logic [W-1:0]  rx_q, rx_d;
  logic [2:0]    rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          xdone_q, xdone_d;
  logic          err_q, err_d;
  logic          frame_q, frame_d;
  logic          start_q, start_d;
  logic [7:0]    tdat_q, tdat_d;
  logic          mlb_q, mlb_d;
  logic [1:0]    cdiv_q, cdiv_d;

  logic          done_rise;
  logic          len_ok;
  logic [7:0]    first_byte;
  logic [7:0]    next_byte;

  assign done_rise = bus.m_done & ~done_q;
  assign len_ok    = (bus.len != 3'd0) && (32'(bus.len) <= 32'(MAX_BYTES));

  // First byte is tx_word byte len-1; later bytes are byte rem-1 after each decrement.
  always_comb begin
    first_byte = '0;
    next_byte  = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (32'(bus.len) == i + 1) first_byte = bus.tx_word[8*i +: 8];
      if (32'(rem_q) == i + 1)   next_byte  = tx_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    xdone_d = 1'b0;
    busy_d  = busy_q;
    err_d   = err_q;
    frame_d = frame_q;
    start_d = start_q;
    tdat_d  = tdat_q;
    mlb_d   = mlb_q;
    cdiv_d  = cdiv_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          ack_d = 1'b1;
          if (len_ok) begin
            tx_d    = bus.tx_word;
            rem_d   = bus.len;
            mlb_d   = bus.mlb_in;
            cdiv_d  = bus.cdiv_in;
            rx_d    = '0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            frame_d = 1'b1;
            start_d = 1'b1;
            tdat_d  = first_byte;
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            xdone_d = 1'b1;
            err_d   = 1'b1;
            rx_d    = '0;
          end
        end
      end
      S_START: begin
        if (cnt_q == CW'(START_LEN - 1)) begin
          start_d = 1'b0;
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (done_rise) begin
          rx_d  = (rx_q << 8) | W'(bus.m_rdata);
          rem_d = rem_q - 3'd1;
          cnt_d = '0;
          if (rem_q == 3'd1) begin
            xdone_d = 1'b1;
            busy_d  = 1'b0;
            frame_d = 1'b0;
            state_d = S_FINISH;
          end else begin
            state_d = S_GAP;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          xdone_d = 1'b1;
          busy_d  = 1'b0;
          frame_d = 1'b0;
          cnt_d   = '0;
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          tdat_d  = next_byte;
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      xdone_q <= 1'b0;
      err_q   <= 1'b0;
      frame_q <= 1'b0;
      start_q <= 1'b0;
      tdat_q  <= '0;
      mlb_q   <= 1'b0;
      cdiv_q  <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      done_q  <= bus.m_done;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      xdone_q <= xdone_d;
      err_q   <= err_d;
      frame_q <= frame_d;
      start_q <= start_d;
      tdat_q  <= tdat_d;
      mlb_q   <= mlb_d;
      cdiv_q  <= cdiv_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.xfer_done = xdone_q;
  assign bus.err       = err_q;
  assign bus.rx_word   = rx_q;
  assign bus.frame     = frame_q;
  assign bus.m_start   = start_q;
  assign bus.m_tdat    = tdat_q;
  assign bus.m_mlb     = mlb_q;
  assign bus.m_cdiv    = cdiv_q;
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Scoreboard bench for spi_xfer_sequencer: a loopback SPI slave model answers each byte,
// stimulus pushes expected acks/bytes/results, and a negedge monitor pops and compares.
module tb_spi_xfer_sequencer;
  localparam int MB = 4;
  localparam int SL = 2;
  localparam int GC = 3;
  localparam int TO = 1023;
  localparam int W  = 8 * MB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_xfer_sequencer_if #(.MAX_BYTES(MB)) bus();

  spi_xfer_sequencer #(
    .MAX_BYTES(MB), .START_LEN(SL), .GAP_CYCLES(GC), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct packed { logic err; logic [W-1:0] rx; } xfer_t;
  typedef struct packed { logic [7:0] tdat; logic mlb; logic [1:0] cdiv; } byte_t;

  xfer_t xq[$];
  byte_t bq[$];
  logic  aq[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit slv_stuck = 1'b0;
  bit slv_inv   = 1'b0;
  int slv_delay = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: expected DUT event did not occur", name);
  endtask

  task automatic check_zero(input string name);
    check(name, 64'({bus.ack, bus.busy, bus.xfer_done, bus.err, bus.frame,
                     bus.m_start, bus.m_mlb, bus.m_cdiv, bus.m_tdat}), 64'(0));
    check({name, "_rx"}, 64'(bus.rx_word), 64'(0));
  endtask

  // Reference model: a legal request sends bytes len-1..0, and with a loopback slave the
  // received word is the used part of tx_word (inverted if the slave inverts).
  task automatic expect_req(input logic [2:0] l, input logic [W-1:0] tx,
                            input logic mlb, input logic [1:0] cd);
    int n = int'(l);
    bit ok = (n >= 1) && (n <= MB);
    logic [W-1:0] mask;
    xfer_t e;
    byte_t b;
    aq.push_back(!ok);
    if (!ok) begin
      e.err = 1'b1;
      e.rx  = '0;
      xq.push_back(e);
      return;
    end
    mask = (n == MB) ? '1 : ((W'(1) << (8 * n)) - W'(1));
    e.err = slv_stuck;
    e.rx  = slv_stuck ? '0 : ((slv_inv ? ~tx : tx) & mask);
    xq.push_back(e);
    for (int k = 0; k < (slv_stuck ? 1 : n); k++) begin
      b.tdat = tx[8*(n-1-k) +: 8];
      b.mlb  = mlb;
      b.cdiv = cd;
      bq.push_back(b);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.busy == 1'b0 && bus.xfer_done == 1'b0 && bus.ack == 1'b0) && n < 5000);
    if (n >= 5000) fail_now("idle_wait");
  endtask

  task automatic wait_ack();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ack && n < 10);
    if (!bus.ack) fail_now("ack_wait");
  endtask

  task automatic issue(input logic [2:0] l, input logic [W-1:0] tx,
                       input logic mlb, input logic [1:0] cd);
    wait_idle();
    expect_req(l, tx, mlb, cd);
    bus.req = 1'b1; bus.len = l; bus.tx_word = tx; bus.mlb_in = mlb; bus.cdiv_in = cd;
    wait_ack();
    bus.req = 1'b0;
    bus.len = 3'($urandom);
    bus.tx_word = W'($urandom);
    bus.mlb_in = 1'($urandom);
    bus.cdiv_in = 2'($urandom);
  endtask

  // Loopback SPI slave: answers each byte some cycles after m_start falls.
  initial begin : slave
    logic [7:0] t;
    int d;
    int n;
    bus.m_done  = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst && bus.m_start && !slv_stuck) begin
        t = bus.m_tdat;
        n = 0;
        while (bus.m_start && n < 64) begin
          @(posedge clk); #1;
          n++;
        end
        d = (slv_delay < 0) ? int'($urandom_range(6, 0)) : slv_delay;
        repeat (d) begin @(posedge clk); #1; end
        bus.m_rdata = slv_inv ? ~t : t;
        bus.m_done  = 1'b1;
        repeat (int'($urandom_range(2, 1))) begin @(posedge clk); #1; end
        bus.m_done  = 1'b0;
        bus.m_rdata = 8'($urandom);
      end
    end
  end

  initial begin : monitor
    logic  prev_start = 1'b0;
    logic  prev_done  = 1'b0;
    logic  armed      = 1'b0;
    int    run = 0;
    int    gap = 0;
    byte_t cur = '0;
    byte_t b;
    xfer_t e;
    logic  r;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_start = 1'b0; prev_done = 1'b0; armed = 1'b0; run = 0; gap = 0;
      end else begin
        if (bus.ack) begin
          if (aq.size() == 0) fail_now("ack_unexpected");
          else begin
            r = aq.pop_front();
            check("ack_xfer_done", 64'(bus.xfer_done), 64'(r));
            check("ack_m_start", 64'(bus.m_start), 64'(!r));
            check("ack_busy", 64'(bus.busy), 64'(!r));
          end
        end
        if (bus.xfer_done) begin
          armed = 1'b0;
          if (xq.size() == 0) fail_now("xfer_done_unexpected");
          else begin
            e = xq.pop_front();
            check("xfer_err", 64'(bus.err), 64'(e.err));
            check("xfer_rx_word", 64'(bus.rx_word), 64'(e.rx));
            check("xfer_busy_frame", 64'({bus.busy, bus.frame}), 64'(0));
          end
        end
        if (bus.m_start && !prev_start) begin
          if (bq.size() == 0) fail_now("m_start_unexpected");
          else begin
            b = bq.pop_front();
            check("byte_tdat_mlb_cdiv", 64'({bus.m_tdat, bus.m_mlb, bus.m_cdiv}), 64'(b));
            check("byte_frame", 64'({bus.frame, bus.busy}), 64'(3));
            if (armed) check("byte_gap", 64'(gap), 64'(GC));
            cur = b;
          end
          armed = 1'b0;
        end
        if (!bus.m_start && prev_start) check("m_start_len", 64'(run), 64'(SL));
        run = bus.m_start ? run + 1 : 0;
        if (bus.m_done && !prev_done && bus.frame) begin
          check("byte_stable_at_done", 64'({bus.m_tdat, bus.m_mlb, bus.m_cdiv}), 64'(cur));
          armed = 1'b1;
          gap = 0;
        end else if (armed && !bus.m_start) begin
          gap++;
        end
        prev_start = bus.m_start;
        prev_done  = bus.m_done;
      end
    end
  end

  initial begin : stim
    logic [W-1:0] tx1, tx2;
    int n, falls;
    logic prev;
    bus.req = 1'b0; bus.len = '0; bus.tx_word = '0; bus.mlb_in = 1'b0; bus.cdiv_in = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;

    issue(3'd1, 32'h0000007C, 1'b0, 2'd0);
    issue(3'd3, 32'h00A1B2C3, 1'b1, 2'd1);
    issue(3'd0, 32'h12345678, 1'b1, 2'd2);
    issue(3'd5, 32'h9ABCDEF0, 1'b0, 2'd3);

    // m_done never arrives: one byte issued, abort after TIMEOUT wait cycles.
    wait_idle();
    slv_stuck = 1'b1;
    issue(3'd2, 32'h0000BEEF, 1'b0, 2'd2);
    n = 0;
    while (bus.m_start && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (!bus.xfer_done && n < 2000) begin @(negedge clk); n++; end
    check("timeout_cycles", 64'(n), 64'(TO));
    wait_idle();
    slv_stuck = 1'b0;

    // Reset during the second byte's WAIT of a four-byte transfer.
    slv_delay = 20;
    issue(3'd4, 32'hC0FFEE11, 1'b1, 2'd3);
    falls = 0; prev = bus.m_start; n = 0;
    while (falls < 2 && n < 500) begin
      @(negedge clk);
      n++;
      if (prev && !bus.m_start) falls++;
      prev = bus.m_start;
    end
    if (falls < 2) fail_now("second_byte_wait");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    xq.delete(); bq.delete(); aq.delete();
    @(negedge clk);
    check_zero("reset_mid_xfer");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    slv_delay = -1;
    issue(3'd1, 32'h0000005A, 1'b1, 2'd1);

    // req held high across a transfer while tx_word changes underneath it.
    wait_idle();
    slv_inv = 1'b0;
    tx1 = W'($urandom);
    tx2 = W'($urandom);
    expect_req(3'd2, tx1, 1'b1, 2'd3);
    expect_req(3'd2, tx2, 1'b1, 2'd3);
    bus.req = 1'b1; bus.len = 3'd2; bus.tx_word = tx1; bus.mlb_in = 1'b1; bus.cdiv_in = 2'd3;
    wait_ack();
    repeat (4) @(negedge clk);
    bus.tx_word = tx2;
    n = 0;
    while (!bus.xfer_done && n < 500) begin @(negedge clk); n++; end
    if (!bus.xfer_done) fail_now("held_req_first_done");
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.ack && n < 10);
    check("held_req_reaccept_delay", 64'(n), 64'(2));
    bus.req = 1'b0;

    for (int i = 0; i < 40; i++) begin
      wait_idle();
      slv_inv = 1'($urandom);
      issue(3'($urandom_range(7, 0)), W'($urandom), 1'($urandom), 2'($urandom));
    end

    wait_idle();
    repeat (5) @(negedge clk);
    check("queues_drained", 64'(xq.size() + bq.size() + aq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_xfer_sequencer.md
Name: spi_xfer_sequencer

Overview:
- Command-side stage directly upstream of spi_master.
- Accepts one multi-byte transaction request (1..MAX_BYTES bytes packed in a word) and feeds spi_master one byte at a time through its start/tdat/mlb/cdiv inputs.
- Waits for spi_master's done after each byte, collects rdata into a receive word, then reports completion.
- Used to program front-end converters and register banks over SPI without per-byte control from higher logic.

Parameters:
MAX_BYTES, 4, maximum bytes per transaction; sets tx_word/rx_word width to 8*MAX_BYTES.
START_LEN, 2, clk cycles m_start is held high per byte.
GAP_CYCLES, 3, idle clk cycles between done of one byte and start of the next.
TIMEOUT, 1023, clk cycles allowed in WAIT before aborting with err.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous active-high reset.
req  in  1  transaction request; sampled only in IDLE.
len  in  3  byte count, valid 1..MAX_BYTES.
tx_word  in  8*MAX_BYTES  transmit bytes; byte len-1 (most significant used byte) is sent first.
mlb_in  in  1  bit order forwarded to spi_master (1 = MSB first).
cdiv_in  in  2  SCK divider forwarded to spi_master.
ack  out  1  one-cycle pulse when a request is accepted or rejected.
busy  out  1  high from acceptance until xfer_done.
xfer_done  out  1  one-cycle pulse at transaction end.
err  out  1  set on reject or timeout; held until next acceptance.
rx_word  out  8*MAX_BYTES  received bytes, first-received in the most significant used byte; held until next acceptance.
frame  out  1  high for the whole multi-byte frame (START through last WAIT).
m_start  out  1  to spi_master start.
m_tdat  out  8  to spi_master tdat.
m_mlb  out  1  to spi_master mlb.
m_cdiv  out  2  to spi_master cdiv.
m_done  in  1  from spi_master done.
m_rdata  in  8  from spi_master rdata.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; done_q 0.
- Reset wins over every other event. A reset mid-transaction drops m_start and frame on that edge, with no xfer_done pulse.
- done_q registers m_done every cycle. done_rise = m_done & ~done_q.
- States: IDLE, START, WAIT, GAP, FINISH.
- IDLE, req=1 and 1<=len<=MAX_BYTES:
  - Latch tx_word, len, mlb_in, cdiv_in; clear rx_word; err<=0.
  - Pulse ack; busy<=1, frame<=1; m_tdat<=byte[len-1].
  - Go to START. m_start rises on the same edge as ack.
- IDLE, req=1 with len=0 or len>MAX_BYTES:
  - Pulse ack and xfer_done on the same cycle; err<=1; rx_word<=0.
  - No SPI activity; stay in IDLE.
- START: m_start high for exactly START_LEN cycles, then drop m_start and go to WAIT; timeout counter cleared.
- m_tdat, m_mlb and m_cdiv are stable from the first START cycle until done_rise for that byte. m_mlb and m_cdiv are stable for the whole frame.
- WAIT:
  - On done_rise: rx_word <= {rx_word[8*MAX_BYTES-9:0], m_rdata}; remaining count decrements.
  - If remaining reaches 0, go to FINISH; otherwise go to GAP.
  - done_rise seen in START or GAP is ignored.
- WAIT timeout: counter increments each WAIT cycle. At TIMEOUT without done_rise, set err<=1, keep rx_word as-is, go to FINISH.
- GAP: GAP_CYCLES cycles with m_start low; load the next m_tdat (the next lower byte), then go to START.
- FINISH: one cycle with xfer_done=1. busy and frame drop on that edge. Return to IDLE.
- req asserted while busy is ignored (not queued). A new request can be accepted on the cycle after FINISH.
- Byte count per transaction is exactly len. Each byte costs START_LEN + WAIT time + (GAP_CYCLES, except after the last byte).

Test Plan:
- len=1, tx_word=0x0000007C, mlb_in=0, cdiv_in=0, slave loopback (din=dout) -> one m_start pulse of 2 cycles, m_tdat=0x7C, rx_word=0x0000007C, xfer_done once, err=0.
- len=3, tx_word=0x00A1B2C3, mlb_in=1, cdiv_in=1, loopback -> m_tdat sequence 0xA1, 0xB2, 0xC3; ≥3 idle cycles between bytes; frame high throughout; rx_word=0x00A1B2C3.
- len=0, then len=5 -> each gives ack+xfer_done on the same cycle with err=1, m_start never asserted.
- m_done tied low, len=2 -> after 1023 WAIT cycles: err=1, xfer_done pulse, only one m_start pulse issued, busy=0.
- rst asserted during the second byte's WAIT of a len=4 transfer -> next edge: all outputs 0, no xfer_done. A subsequent len=1 request completes normally.
- req held high across a len=2 transfer with differing tx_word mid-way -> only the first request executes; the latched bytes are unaffected; the second is accepted only after xfer_done.
